// File: rtl/ddr5_closed_page_scheduler_pkg.sv
// Shared types and defaults for the closed-page DDR5 command scheduler.
//   commands_e     : command codes driven on cmd (NOP is the reset/idle code)
//   oper_e         : request operation encoding on req_op
//   add_map_t      : field layout of the 34-bit physical address
//   req_t          : 36-bit FIFO payload {op, address}
//   sched_state_e  : scheduler FSM states
//   DEF_*          : default FIFO depth and timing values (DIMM clock cycles)
package ddr5_closed_page_scheduler_pkg;

    typedef enum logic [3:0] {
        CMD_NOP  = 4'd0,
        CMD_ACT0 = 4'd1,
        CMD_ACT1 = 4'd2,
        CMD_RD0  = 4'd3,
        CMD_RD1  = 4'd4,
        CMD_WR0  = 4'd5,
        CMD_WR1  = 4'd6,
        CMD_PRE  = 4'd7
    } commands_e;

    typedef enum logic [1:0] {
        OP_D_READ  = 2'd0,
        OP_WRITE   = 2'd1,
        OP_I_READ  = 2'd2,
        OP_ILLEGAL = 2'd3
    } oper_e;

    // MSB first: row[33:18], col_high[17:12], bank[11:10], bg[9:7],
    // channel[6], col_low[5:2], byte offset[1:0].
    typedef struct packed {
        logic [15:0] row;
        logic [5:0]  col_high;
        logic [1:0]  bank;
        logic [2:0]  bg;
        logic        channel;
        logic [3:0]  col_low;
        logic [1:0]  byte_off;
    } add_map_t;

    typedef struct packed {
        oper_e    op;
        add_map_t addr;
    } req_t;

    localparam int REQ_W       = 36;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_T_RCD   = 39;
    localparam int DEF_T_RAS   = 76;
    localparam int DEF_T_RTP   = 18;
    localparam int DEF_T_CWD   = 38;
    localparam int DEF_T_BURST = 8;
    localparam int DEF_T_WR    = 72;
    localparam int DEF_T_RP    = 39;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ACT0     = 4'd1,
        ST_ACT1     = 4'd2,
        ST_WAIT_RCD = 4'd3,
        ST_CAS0     = 4'd4,
        ST_CAS1     = 4'd5,
        ST_WAIT_PRE = 4'd6,
        ST_PRE      = 4'd7,
        ST_WAIT_RP  = 4'd8
    } sched_state_e;

    // 8-bit saturating increment used by all timing counters.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ddr5_closed_page_scheduler_sched_req_fifo.sv
// Request FIFO for the DDR5 scheduler. Pointer-based circular buffer with an
// extra wrap bit to tell full from empty. Read data is the head entry,
// available combinationally so the scheduler can decode it in the pop cycle.
//   clk_i, rst_i      : clock, asynchronous active-high reset (clears pointers)
//   push_i, din_i     : write request and payload (ignored when full)
//   pop_i, dout_o     : remove head entry (ignored when empty), head payload
//   full_o, empty_o   : occupancy flags
module sched_req_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 36
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sched_req_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= din_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

endmodule

// File: rtl/ddr5_closed_page_scheduler.sv
// In-order closed-page DDR5 command scheduler for one channel. Each request is
// expanded into ACT0/ACT1, RD0/RD1 or WR0/WR1, then PRE, honouring tRCD, tRAS,
// tRTP, write recovery (tCWD+tBURST+tWR) and tRP.
//   clock, reset        : DIMM clock, asynchronous active-high reset
//   req_valid/req_ready : request handshake (ready = FIFO not full)
//   req_addr, req_op    : 34-bit address (add_map_t), operation (oper_e)
//   cmd_valid, cmd      : registered command strobe and code (commands_e)
//   cmd_bg/bank/row/col : target fields, held when no command is issued
//   done                : pulse with the PRE of each request
//   err                 : pulse when an op-3 request is dropped
module ddr5_closed_page_scheduler
    import ddr5_closed_page_scheduler_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int T_RCD   = DEF_T_RCD,
    parameter int T_RAS   = DEF_T_RAS,
    parameter int T_RTP   = DEF_T_RTP,
    parameter int T_CWD   = DEF_T_CWD,
    parameter int T_BURST = DEF_T_BURST,
    parameter int T_WR    = DEF_T_WR,
    parameter int T_RP    = DEF_T_RP
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [33:0] req_addr,
    input  logic [1:0]  req_op,
    output logic        cmd_valid,
    output logic [3:0]  cmd,
    output logic [2:0]  cmd_bg,
    output logic [1:0]  cmd_bank,
    output logic [15:0] cmd_row,
    output logic [9:0]  cmd_col,
    output logic        done,
    output logic        err
);

    localparam int WR_TO_PRE = T_CWD + T_BURST + T_WR;

    if (T_RCD < 3 || T_RCD > 255 || T_RAS < 1 || T_RAS > 255 ||
        T_RTP < 1 || T_RTP > 255 || T_CWD > 255 || T_BURST > 255 ||
        T_WR > 255 || WR_TO_PRE < 1 || WR_TO_PRE > 255 ||
        T_RP < 3 || T_RP > 255) begin : g_bad_timing
        $error("ddr5_closed_page_scheduler: timing parameters out of 8-bit counter range");
    end

    // Counters read 1 on the edge after their start command, so a command at
    // edge S+T needs the state change one edge earlier: threshold T-1. Leaving
    // WAIT_RP costs one extra IDLE cycle before ACT0, hence T_RP-2.
    localparam logic [7:0] RCD_THR = 8'(T_RCD - 1);
    localparam logic [7:0] RAS_THR = 8'(T_RAS - 1);
    localparam logic [7:0] RTP_THR = 8'(T_RTP - 1);
    localparam logic [7:0] WRP_THR = 8'(WR_TO_PRE - 1);
    localparam logic [7:0] RP_THR  = 8'(T_RP - 2);

    sched_state_e state_q, state_d;
    req_t         req_q, req_d;
    req_t         fifo_dout;
    logic         fifo_full, fifo_empty, fifo_pop;
    logic [7:0]   ras_cnt_q, cas_cnt_q, rp_cnt_q;
    logic         is_write, issue, done_d, err_d;
    commands_e    cmd_sel;
    logic         unused_addr_bits;

    commands_e    cmd_q;
    logic         cmd_valid_q, done_q, err_q;
    logic [2:0]   bg_q;
    logic [1:0]   bank_q;
    logic [15:0]  row_q;
    logic [9:0]   col_q;

    // No bypass: a full FIFO refuses a push even when it pops the same cycle.
    assign req_ready = !reset && !fifo_full;
    assign is_write  = (req_q.op == OP_WRITE);
    assign unused_addr_bits = ^{req_q.addr.channel, req_q.addr.byte_off};

    sched_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (req_valid && req_ready),
        .din_i   ({req_op, req_addr}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        fifo_pop = 1'b0;
        issue    = 1'b0;
        cmd_sel  = CMD_NOP;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (fifo_dout.op == OP_ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        req_d   = fifo_dout;
                        state_d = ST_ACT0;
                    end
                end
            end
            ST_ACT0: begin
                issue   = 1'b1;
                cmd_sel = CMD_ACT0;
                state_d = ST_ACT1;
            end
            ST_ACT1: begin
                issue   = 1'b1;
                cmd_sel = CMD_ACT1;
                state_d = ST_WAIT_RCD;
            end
            ST_WAIT_RCD: begin
                if (ras_cnt_q >= RCD_THR) state_d = ST_CAS0;
            end
            ST_CAS0: begin
                issue   = 1'b1;
                cmd_sel = is_write ? CMD_WR0 : CMD_RD0;
                state_d = ST_CAS1;
            end
            ST_CAS1: begin
                issue   = 1'b1;
                cmd_sel = is_write ? CMD_WR1 : CMD_RD1;
                state_d = ST_WAIT_PRE;
            end
            ST_WAIT_PRE: begin
                if ((ras_cnt_q >= RAS_THR) &&
                    (cas_cnt_q >= (is_write ? WRP_THR : RTP_THR))) begin
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                issue   = 1'b1;
                cmd_sel = CMD_PRE;
                done_d  = 1'b1;
                state_d = ST_WAIT_RP;
            end
            ST_WAIT_RP: begin
                if (rp_cnt_q >= RP_THR) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            ras_cnt_q   <= '0;
            cas_cnt_q   <= '0;
            rp_cnt_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            bg_q        <= '0;
            bank_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            // Each counter restarts on the edge its reference command is issued.
            ras_cnt_q   <= (state_q == ST_ACT0) ? 8'd1 : sat_inc(ras_cnt_q);
            cas_cnt_q   <= (state_q == ST_CAS0) ? 8'd1 : sat_inc(cas_cnt_q);
            rp_cnt_q    <= (state_q == ST_PRE)  ? 8'd1 : sat_inc(rp_cnt_q);
            cmd_valid_q <= issue;
            done_q      <= done_d;
            err_q       <= err_d;
            if (issue) begin
                cmd_q  <= cmd_sel;
                bg_q   <= req_q.addr.bg;
                bank_q <= req_q.addr.bank;
                row_q  <= req_q.addr.row;
                col_q  <= {req_q.addr.col_high, req_q.addr.col_low};
            end
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign cmd_bg    = bg_q;
    assign cmd_bank  = bank_q;
    assign cmd_row   = row_q;
    assign cmd_col   = col_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ddr5_closed_page_scheduler.sv
// Self-checking bench for ddr5_closed_page_scheduler. A timestamp-level model
// derives every command's edge from the timing rules; a negedge process
// compares all outputs every cycle, and directed tests pin literal edges.
module tb_ddr5_closed_page_scheduler;

    localparam int DEPTH   = 16;
    localparam int T_RCD   = 39;
    localparam int T_RAS   = 76;
    localparam int T_RTP   = 18;
    localparam int T_CWD   = 38;
    localparam int T_BURST = 8;
    localparam int T_WR    = 72;
    localparam int T_RP    = 39;

    localparam logic [3:0] C_ACT0 = 4'd1;
    localparam logic [3:0] C_ACT1 = 4'd2;
    localparam logic [3:0] C_RD0  = 4'd3;
    localparam logic [3:0] C_RD1  = 4'd4;
    localparam logic [3:0] C_WR0  = 4'd5;
    localparam logic [3:0] C_WR1  = 4'd6;
    localparam logic [3:0] C_PRE  = 4'd7;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [33:0] req_addr = '0;
    logic [1:0]  req_op = '0;
    logic        cmd_valid;
    logic [3:0]  cmd;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        done;
    logic        err;

    always #5 clock = ~clock;

    ddr5_closed_page_scheduler dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_op    (req_op),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_bg    (cmd_bg),
        .cmd_bank  (cmd_bank),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [3:0]  c;
        logic [2:0]  bg;
        logic [1:0]  bank;
        logic [15:0] row;
        logic [9:0]  col;
        bit          dn;
    } ev_t;

    typedef struct {
        logic [1:0]  op;
        logic [33:0] addr;
    } rq_t;

    typedef struct {
        int  e;
        ev_t ev;
    } lg_t;

    // ---------------- model state ----------------
    rq_t  q[$];
    ev_t  sched[int];
    bit   err_sched[int];
    int   cyc = 0;
    int   idle_edge = 0;
    bit   m_rdy;
    rq_t  m_r;
    bit   exp_valid = 0, exp_done = 0, exp_err = 0, exp_ready = 1;
    ev_t  exp_last = '{default: 0};

    // ---------------- bookkeeping ----------------
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 0;
    lg_t  log_q[$];
    int   err_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic void add_ev(input int e, input logic [3:0] c, input rq_t r, input bit dn);
        ev_t ev;
        ev.c    = c;
        ev.row  = r.addr[33:18];
        ev.col  = {r.addr[17:12], r.addr[5:2]};
        ev.bank = r.addr[11:10];
        ev.bg   = r.addr[9:7];
        ev.dn   = dn;
        sched[e] = ev;
    endfunction

    // Whole-request schedule from the timing rules, given the pop edge.
    function automatic void schedule(input int pop_e, input rq_t r);
        int a, cas, pre, rec;
        bit wr;
        wr  = (r.op == 2'd1);
        a   = pop_e + 1;
        cas = a + T_RCD;
        rec = wr ? (T_CWD + T_BURST + T_WR) : T_RTP;
        pre = (a + T_RAS > cas + rec) ? a + T_RAS : cas + rec;
        add_ev(a,       C_ACT0, r, 1'b0);
        add_ev(a + 1,   C_ACT1, r, 1'b0);
        add_ev(cas,     wr ? C_WR0 : C_RD0, r, 1'b0);
        add_ev(cas + 1, wr ? C_WR1 : C_RD1, r, 1'b0);
        add_ev(pre,     C_PRE, r, 1'b1);
        idle_edge = pre + T_RP - 1;
    endfunction

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                q.delete();
                sched.delete();
                err_sched.delete();
                idle_edge = 0;
                exp_valid = 0;
                exp_done  = 0;
                exp_err   = 0;
                exp_ready = 1;
                exp_last  = '{default: 0};
            end else begin
                cyc++;
                m_rdy = (q.size() < DEPTH);
                if (cyc >= idle_edge && q.size() > 0) begin
                    m_r = q.pop_front();
                    if (m_r.op == 2'd3) begin
                        err_sched[cyc] = 1'b1;
                        idle_edge = cyc + 1;
                    end else begin
                        schedule(cyc, m_r);
                    end
                end
                if (req_valid && m_rdy) begin
                    m_r.op   = req_op;
                    m_r.addr = req_addr;
                    q.push_back(m_r);
                end
                exp_ready = (q.size() < DEPTH);
                if (sched.exists(cyc)) begin
                    exp_valid = 1;
                    exp_last  = sched[cyc];
                    exp_done  = sched[cyc].dn;
                    sched.delete(cyc);
                end else begin
                    exp_valid = 0;
                    exp_done  = 0;
                end
                exp_err = err_sched.exists(cyc);
                if (exp_err) err_sched.delete(cyc);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        lg_t l;
        forever begin
            @(negedge clock);
            if (chk_en) begin
                chk("req_ready", req_ready, reset ? 1'b0 : exp_ready);
                chk("cmd_valid", cmd_valid, exp_valid);
                chk("cmd",       cmd,       exp_last.c);
                chk("cmd_bg",    cmd_bg,    exp_last.bg);
                chk("cmd_bank",  cmd_bank,  exp_last.bank);
                chk("cmd_row",   cmd_row,   exp_last.row);
                chk("cmd_col",   cmd_col,   exp_last.col);
                chk("done",      done,      exp_done);
                chk("err",       err,       exp_err);
                if (cmd_valid) begin
                    l.e = cyc;
                    l.ev.c = cmd; l.ev.bg = cmd_bg; l.ev.bank = cmd_bank;
                    l.ev.row = cmd_row; l.ev.col = cmd_col; l.ev.dn = done;
                    log_q.push_back(l);
                    $display("[TB] edge=%0d cmd=%0d bg=%0d bank=%0d row=%h col=%h done=%0b",
                             cyc, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col, done);
                end
                if (err) begin
                    err_log.push_back(cyc);
                    $display("[TB] edge=%0d err pulse", cyc);
                end
            end
        end
    end

    function automatic lg_t lg_at(input logic [3:0] c, input int nth);
        lg_t r;
        int  n;
        r.e = -1;
        r.ev = '{default: 0};
        n = 0;
        foreach (log_q[i]) begin
            if (log_q[i].ev.c == c) begin
                if (n == nth) return log_q[i];
                n++;
            end
        end
        return r;
    endfunction

    function automatic int count_of(input logic [3:0] c);
        int n;
        n = 0;
        foreach (log_q[i]) if (log_q[i].ev.c == c) n++;
        return n;
    endfunction

    function automatic logic [33:0] mk_addr(input logic [15:0] row, input logic [2:0] bg,
                                            input logic [1:0] bank, input logic [9:0] col);
        // channel bit and byte offset set to 1s: they must be ignored
        return {row, col[9:4], bank, bg, 1'b1, col[3:0], 2'b11};
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Called at posedge+1; presents a request for one edge.
    task automatic put(input logic [1:0] op, input logic [33:0] a, output int e, output bit acc);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        acc       = req_ready;
        @(posedge clock);
        #1;
        e = cyc;
    endtask

    task automatic idle_in();
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        n_fail++;
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2, e, acc;
        bit a;
        lg_t l;

        // ---- reset state ----
        repeat (3) @(posedge clock);
        #1;
        chk_en = 1;
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_req_ready", req_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", req_ready, 1'b1);
        wait_cyc(2);

        // ---- single read ----
        log_q.delete();
        put(2'd0, mk_addr(16'h1234, 3'd5, 2'd2, 10'h155), k, a);
        idle_in();
        wait_cyc(130);
        l = lg_at(C_ACT0, 0); chk("rd_act0_edge", l.e, k + 2);
        chk("rd_act0_row", l.ev.row, 16'h1234);
        chk("rd_act0_bg", l.ev.bg, 3'd5);
        chk("rd_act0_bank", l.ev.bank, 2'd2);
        l = lg_at(C_ACT1, 0); chk("rd_act1_edge", l.e, k + 3);
        l = lg_at(C_RD0, 0);  chk("rd_rd0_edge", l.e, k + 41);
        chk("rd_rd0_col", l.ev.col, 10'h155);
        l = lg_at(C_RD1, 0);  chk("rd_rd1_edge", l.e, k + 42);
        l = lg_at(C_PRE, 0);  chk("rd_pre_edge", l.e, k + 78);
        chk("rd_pre_done", l.ev.dn, 1'b1);
        chk("rd_pre_bank", l.ev.bank, 2'd2);

        // ---- single write ----
        log_q.delete();
        put(2'd1, mk_addr(16'h0ABC, 3'd3, 2'd1, 10'h2A7), k, a);
        idle_in();
        wait_cyc(210);
        l = lg_at(C_ACT0, 0); chk("wr_act0_edge", l.e, k + 2);
        l = lg_at(C_WR0, 0);  chk("wr_wr0_edge", l.e, k + 41);
        chk("wr_wr0_col", l.ev.col, 10'h2A7);
        l = lg_at(C_WR1, 0);  chk("wr_wr1_edge", l.e, k + 42);
        l = lg_at(C_PRE, 0);  chk("wr_pre_edge", l.e, k + 159);

        // ---- two back-to-back reads ----
        log_q.delete();
        put(2'd0, mk_addr(16'h0001, 3'd1, 2'd0, 10'h001), k, a);
        put(2'd2, mk_addr(16'h0002, 3'd2, 2'd3, 10'h3FF), e, a);
        idle_in();
        wait_cyc(250);
        l = lg_at(C_PRE, 0);  chk("rr_first_pre", l.e, k + 78);
        l = lg_at(C_ACT0, 1); chk("rr_second_act0", l.e, k + 117);
        chk("rr_second_row", l.ev.row, 16'h0002);

        // ---- FIFO fill: 17 pushes while the FSM is busy ----
        log_q.delete();
        put(2'd0, mk_addr(16'h03FF, 3'd7, 2'd3, 10'h000), k, a);
        idle_in();
        wait_cyc(5);
        acc = 0;
        for (int i = 0; i < 17; i++) begin
            put(2'd0, mk_addr(16'(i), 3'(i), 2'(i), 10'(i * 3)), e, a);
            if (a) acc++;
        end
        idle_in();
        chk("fill_accepts", acc, 16);
        chk("fill_ready_low", req_ready, 1'b0);
        wait_cyc(2100);
        chk("fill_done_count", count_of(C_PRE), 17);
        l = lg_at(C_ACT0, 1);  chk("fill_first_row", l.ev.row, 16'd0);
        l = lg_at(C_ACT0, 16); chk("fill_last_row", l.ev.row, 16'd15);

        // ---- illegal op between two reads ----
        log_q.delete();
        err_log.delete();
        put(2'd0, mk_addr(16'h0111, 3'd0, 2'd1, 10'h011), k, a);
        put(2'd3, mk_addr(16'h0FFF, 3'd6, 2'd2, 10'h0EE), e, a);
        put(2'd0, mk_addr(16'h0222, 3'd4, 2'd2, 10'h022), e, a);
        idle_in();
        wait_cyc(260);
        chk("ill_err_count", err_log.size(), 1);
        if (err_log.size() > 0) chk("ill_err_edge", err_log[0], k + 116);
        chk("ill_act0_count", count_of(C_ACT0), 2);
        l = lg_at(C_ACT0, 1); chk("ill_second_act0", l.e, k + 118);
        chk("ill_second_row", l.ev.row, 16'h0222);

        // ---- reset during WAIT_RCD ----
        log_q.delete();
        put(2'd0, mk_addr(16'h0333, 3'd2, 2'd1, 10'h033), k, a);
        put(2'd0, mk_addr(16'h0444, 3'd3, 2'd0, 10'h044), e, a);
        idle_in();
        wait_cyc(8);
        reset = 1'b1;
        #1;
        chk("mid_rst_cmd_valid", cmd_valid, 1'b0);
        chk("mid_rst_cmd", cmd, 4'd0);
        chk("mid_rst_row", cmd_row, 16'd0);
        chk("mid_rst_ready", req_ready, 1'b0);
        wait_cyc(2);
        reset = 1'b0;
        log_q.delete();
        wait_cyc(120);
        chk("post_rst_no_cmds", log_q.size(), 0);
        put(2'd0, mk_addr(16'h0555, 3'd5, 2'd1, 10'h055), k2, a);
        idle_in();
        wait_cyc(130);
        l = lg_at(C_ACT0, 0); chk("post_rst_act0", l.e, k2 + 2);
        chk("post_rst_row", l.ev.row, 16'h0555);
        l = lg_at(C_PRE, 0);  chk("post_rst_pre", l.e, k2 + 78);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr5_closed_page_scheduler.md
Name: ddr5_closed_page_scheduler

Overview:
- In-order, closed-page DDR5 command scheduler for one channel; sits between the trace-driven request queue and the DIMM command output/logger.
- Accepts CPU requests (34-bit address, operation), buffers them in a FIFO, and decomposes each into ACT0/ACT1, RD0/RD1 or WR0/WR1, PRE.
- Enforces tRCD, tRAS, tRTP, tCWD+tBURST+tWR and tRP, counted in DIMM clock cycles.

Parameters:
- DEPTH, 16, request FIFO entries (power of 2).
- T_RCD, 39, ACT0 to RD0/WR0 minimum.
- T_RAS, 76, ACT0 to PRE minimum.
- T_RTP, 18, RD0 to PRE minimum.
- T_CWD, 38, WR0 to write-data start.
- T_BURST, 8, data burst length.
- T_WR, 72, end of write burst to PRE.
- T_RP, 39, PRE to next ACT0 minimum.

Ports:
- clock  in  1  DIMM clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept.
- req_addr  in  34  physical address, add_map layout.
- req_op  in  2  oper encoding: 0 d_read, 1 write, 2 i_read.
- cmd_valid  out  1  command issued this cycle.
- cmd  out  4  commands enum.
- cmd_bg  out  3  bank group.
- cmd_bank  out  2  bank.
- cmd_row  out  16  row, valid on ACT0/ACT1.
- cmd_col  out  10  {col_high,col_low}, valid on RD*/WR*.
- done  out  1  one-cycle pulse when PRE for a request is issued.
- err  out  1  one-cycle pulse when an illegal op (3) is dropped.

Behaviour:
- Reset clears the FIFO, sets the FSM to IDLE and clears all counters. All outputs go to 0; req_ready is 1 once reset deasserts.
- Reset mid-sequence abandons the sequence with no PRE issued.
- FIFO: push when req_valid && req_ready. req_ready = !full; there is no bypass, so a full FIFO refuses a push even in a cycle that also pops. Pop occurs only in IDLE.
- Address fields: row = addr[33:18], col = {addr[17:12], addr[5:2]}, bank = addr[11:10], bg = addr[9:7]. addr[6] (channel) and addr[1:0] are ignored.
- Outputs are registered. A request pushed at edge k into an empty FIFO with the FSM in IDLE yields ACT0 at edge k+2.
- FSM states: IDLE, ACT0, ACT1, WAIT_RCD, CAS0, CAS1, WAIT_PRE, PRE, WAIT_RP.
  - IDLE: if the FIFO is non-empty, pop. Op 3 pulses err and stays in IDLE; otherwise load the request and go to ACT0.
  - ACT0: emit ACT0 and start the RAS counter. ACT1 follows in the next cycle.
  - WAIT_RCD: hold until T_RCD cycles after ACT0.
  - CAS0/CAS1: emit RD0/RD1 for ops 0 and 2, or WR0/WR1 for op 1.
  - WAIT_PRE: hold until the PRE constraint is met.
    - Read: PRE earliest at max(ACT0+T_RAS, RD0+T_RTP).
    - Write: PRE earliest at max(ACT0+T_RAS, WR0+T_CWD+T_BURST+T_WR).
  - PRE: emit PRE with the same bg/bank and pulse done.
  - WAIT_RP: hold until PRE+T_RP, then return to IDLE. The next ACT0 is therefore never earlier than PRE+T_RP.
- When no command is issued, cmd_valid=0 and cmd/bg/bank/row/col hold their last values.
- Counters are 8-bit, saturating, with no wrap. All timing parameters must be below 256; this is enforced by an elaboration-time check.
- A push in the same cycle as a pop from a non-full FIFO is legal, and occupancy is unchanged.

Decomposition:
- Shared package: commands and oper enums, add_map struct, timing defaults as localparams, FSM state enum.
- One natural sub-module: sched_req_fifo (parameterised DEPTH, 36-bit payload, push/pop/full/empty). Without it the block is a single FSM plus counters.

Test Plan:
- Single read (op 0, row 0x1234, bg 5, bank 2, col 0x155) pushed at edge k:
  - ACT0@k+2, ACT1@k+3, RD0@k+41, RD1@k+42, PRE@k+78 with done=1.
  - cmd_row=0x1234, cmd_bg=5, cmd_bank=2, cmd_col=0x155.
- Single write pushed at edge k: ACT0@k+2, WR0@k+41, WR1@k+42, PRE@k+159.
- Two reads pushed at k and k+1: second ACT0@k+117, which is first PRE+39.
- 17 back-to-back pushes: req_ready drops after 16 accepts; 16 done pulses follow, in push order.
- Op 3 pushed between two reads: err pulses once, no commands for it, and the second read proceeds normally.
- Reset asserted during WAIT_RCD: outputs go to 0 immediately, the FIFO is empty, and no PRE is issued; a new request after reset starts at ACT0 with 2-cycle latency.
